spiflash_responder: RTL and testbench
=====================================

// Module: spiflash_responder
// PURPOSE
//  Synthesizable SPI flash emulator: the target end of the picosoc flash interface (csb/clk/io0/io1).
//  Backs a PicoRV32 SoC boot image with on-chip block RAM so boards without a QSPI part can run firmware.
//  Oversamples the SPI pins with the system clock and implements single-bit mode 0 commands only.
//  Supported commands: 0x03 READ, 0x0B FAST READ, 0x9F JEDEC ID, 0xAB release power-down, 0xFF reset.
// PARAMETERS
//  ADDR_W   14        byte-address width of backing memory (MEM bytes = 2**ADDR_W)
//  JEDEC_ID 24'hEF4018 three ID bytes returned by 0x9F, MSB byte first
// PORTS
//  clk          in   1       system clock; must be >= 8x spi_clk frequency
//  resetn       in   1       synchronous active-low reset
//  spi_csb      in   1       chip select from initiator, active low (async to clk)
//  spi_clk      in   1       SPI clock, idles low (mode 0, async to clk)
//  spi_mosi     in   1       io0 from initiator
//  spi_miso     out  1       io1 data to initiator
//  spi_miso_oe  out  1       1 = drive spi_miso onto pad, 0 = tristate
//  load_we      in   1       write one byte into backing memory
//  load_addr    in   ADDR_W  load byte address
//  load_data    in   8       load byte
//  busy         out  1       1 while synchronized csb is low
//  last_cmd     out  8       most recent opcode received (any value)
// BEHAVIOUR
//  - Reset: spi_miso=0, spi_miso_oe=0, busy=0, last_cmd=8'h00, state IDLE; memory contents untouched.
//  - csb, sclk, mosi each pass a 2-FF synchronizer; edges detected on synchronized values (sclk rise = sample,
//    sclk fall = shift out). Rise/fall pulses occur 3 clk after the pad edge.
//  - States: IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE.
//  - IDLE: synchronized csb falling -> CMD, bit count 0, busy=1.
//  - CMD: shift mosi MSB-first on 8 sclk rises; on 8th rise latch last_cmd and decode:
//    0x03 -> ADDR; 0x0B -> ADDR; 0x9F -> ID; 0xAB, 0xFF, any other -> IGNORE.
//  - ADDR: 24 bits MSB-first; address = low ADDR_W bits (upper bits ignored = wrap).
//    After 24th rise: 0x03 -> DATA, 0x0B -> DUMMY (8 further rises, then DATA).
//  - Memory read is synchronous, 1 clk; byte fetched on entry to DATA and on each byte boundary.
//  - DATA: on each sclk fall drive next bit MSB-first with oe=1; first bit driven on the fall that follows
//    the last addr/dummy rise. After 8 bits address+1, wrapping 2**ADDR_W-1 -> 0; streaming unbounded.
//  - ID: as DATA but sources JEDEC_ID bytes; after 3 bytes drive 0 with oe=1 until csb high.
//  - IGNORE: oe=0, all sclk edges ignored until csb high.
//  - Synchronized csb rising in any state -> IDLE in same clk: oe=0, miso=0, busy=0, partial bytes/addr discarded.
//  - sclk edges while csb high are ignored. csb low with no sclk holds state indefinitely.
//  - load_we writes memory every clk it is high, regardless of SPI state; a read of the same address
//    in the same clk returns the old byte.
//  - Timing budget: sclk high and low phases each >= 4 clk so fall->miso (3 sync + 1 reg) precedes next rise.
// TESTING
//  - Load 0x00..0x03 = 11 22 33 44; READ 03 000000, clock 32 bits -> miso bytes 11 22 33 44, oe=1 in DATA.
//  - FAST READ 0B 000002 + 8 dummy clocks -> first byte 0x33, oe stays 0 through dummy phase.
//  - ADDR_W=14, READ at 0x003FFF with mem[3FFF]=0xA5, mem[0]=0x11 -> bytes A5 then 11 (wrap);
//    addr 0x0C3FFF gives identical result.
//  - 0x9F then 32 clocks -> EF 40 18 00; 0xFF then 0xAB -> oe=0 throughout, last_cmd=0xAB.
//  - Raise csb after 12 addr bits, then new READ 03 000001 -> clean restart, first byte 0x22; busy low
//    within 3 clk of csb rise; resetn low mid-DATA -> oe=0, last_cmd=0 next clk.

Source files
------------

// File: rtl/spiflash_responder.sv
// SPI flash target for picosoc boot: oversampled mode-0 single-bit READ / FAST READ / JEDEC ID
// backed by an on-chip byte RAM that the host side can preload through the load port.
module spiflash_responder #(
    parameter int          ADDR_W   = 14,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_csb,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy,
    output logic [7:0]        last_cmd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_ID,
        S_IGNORE
    } state_t;

    state_t state, state_n;

    // Two synchronizer flops plus one history flop for edge detection.
    logic [2:0] csb_sr, sclk_sr;
    logic [1:0] mosi_sr;
    logic       csb_fall, csb_rise, sclk_rise, sclk_fall, mosi_s;

    logic [4:0]        cnt, cnt_n;
    logic [23:0]       sh, sh_n, shift_in;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [1:0]        id_idx, id_idx_n;
    logic              miso_n, oe_n;
    logic [7:0]        last_cmd_n;
    logic [7:0]        mem_q;
    logic [7:0]        id_byte;

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            csb_sr  <= 3'b111;
            sclk_sr <= 3'b000;
            mosi_sr <= 2'b00;
        end else begin
            csb_sr  <= {csb_sr[1:0], spi_csb};
            sclk_sr <= {sclk_sr[1:0], spi_clk};
            mosi_sr <= {mosi_sr[0], spi_mosi};
        end
    end

    assign csb_fall  = !csb_sr[1] &&  csb_sr[2];
    assign csb_rise  =  csb_sr[1] && !csb_sr[2];
    assign sclk_rise =  sclk_sr[1] && !sclk_sr[2];
    assign sclk_fall = !sclk_sr[1] &&  sclk_sr[2];
    assign mosi_s    =  mosi_sr[1];
    assign shift_in  = {sh[22:0], mosi_s};

    // Host writes take priority in the array; a same-address read sees the old byte.
    always_ff @(posedge clk) begin
        if (load_we)
            mem[load_addr] <= load_data;
        mem_q <= mem[addr];
    end

    always_comb begin
        case (id_idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        sh_n       = sh;
        addr_n     = addr;
        miso_n     = spi_miso;
        oe_n       = spi_miso_oe;
        last_cmd_n = last_cmd;
        id_idx_n   = id_idx;

        if (csb_rise) begin
            state_n = S_IDLE;
            cnt_n   = 5'd0;
            miso_n  = 1'b0;
            oe_n    = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (csb_fall) begin
                        state_n = S_CMD;
                        cnt_n   = 5'd0;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        sh_n  = shift_in;
                        cnt_n = cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt_n      = 5'd0;
                            last_cmd_n = shift_in[7:0];
                            case (shift_in[7:0])
                                8'h03, 8'h0B: state_n = S_ADDR;
                                8'h9F: begin
                                    state_n  = S_ID;
                                    id_idx_n = 2'd0;
                                end
                                default: state_n = S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (sclk_rise) begin
                        sh_n  = shift_in;
                        cnt_n = cnt + 5'd1;
                        if (cnt == 5'd23) begin
                            cnt_n   = 5'd0;
                            addr_n  = shift_in[ADDR_W-1:0];
                            state_n = (last_cmd == 8'h0B) ? S_DUMMY : S_DATA;
                        end
                    end
                end
                S_DUMMY: begin
                    if (sclk_rise) begin
                        cnt_n = cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt_n   = 5'd0;
                            state_n = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (sclk_fall) begin
                        miso_n = mem_q[3'd7 - cnt[2:0]];
                        oe_n   = 1'b1;
                        cnt_n  = cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt_n  = 5'd0;
                            addr_n = addr + 1'b1;
                        end
                    end
                end
                S_ID: begin
                    if (sclk_fall) begin
                        miso_n = id_byte[3'd7 - cnt[2:0]];
                        oe_n   = 1'b1;
                        cnt_n  = cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt_n = 5'd0;
                            if (id_idx != 2'd3)
                                id_idx_n = id_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    oe_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            cnt         <= 5'd0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            last_cmd    <= 8'h00;
            id_idx      <= 2'd0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            spi_miso    <= miso_n;
            spi_miso_oe <= oe_n;
            last_cmd    <= last_cmd_n;
            id_idx      <= id_idx_n;
        end
    end

    // Shift and address registers carry data only; the FSM qualifies every use.
    always_ff @(posedge clk) begin
        sh   <= sh_n;
        addr <= addr_n;
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_spiflash_responder.sv
// Bench for spiflash_responder: directed flash transactions plus randomized reads checked
// against a byte-array flash model.
module tb_spiflash_responder;

    localparam int ADDR_W = 14;
    localparam int MEM    = 2**ADDR_W;
    localparam int HALF   = 5;

    logic              clk = 1'b0;
    logic              resetn;
    logic              spi_csb, spi_clk, spi_mosi;
    logic              spi_miso, spi_miso_oe;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              busy;
    logic [7:0]        last_cmd;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_model [MEM];

    spiflash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(24'hEF4018)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .spi_csb     (spi_csb),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .busy        (busy),
        .last_cmd    (last_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [7:0] d);
        load_we   = 1'b1;
        load_addr = a[ADDR_W-1:0];
        load_data = d;
        clks(1);
        load_we = 1'b0;
        mem_model[a % MEM] = d;
    endtask

    // Mode 0: drive mosi and sample miso while sclk is low, then rise and fall.
    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx,
                             output logic oe_all, output logic oe_any);
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            spi_mosi = tx[b];
            clks(HALF);
            rx[b]  = spi_miso;
            oe_all = oe_all & spi_miso_oe;
            oe_any = oe_any | spi_miso_oe;
            spi_clk = 1'b1;
            clks(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_lo();
        spi_csb = 1'b0;
        clks(HALF);
    endtask

    task automatic cs_hi();
        spi_csb = 1'b1;
        clks(2*HALF);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] rx;
        logic       oa, oo;
        xfer_byte(cmd, rx, oa, oo);
        xfer_byte(a[23:16], rx, oa, oo);
        xfer_byte(a[15:8], rx, oa, oo);
        xfer_byte(a[7:0], rx, oa, oo);
    endtask

    // Full read transaction; expected bytes come from the model with address wrap.
    task automatic do_read(input string tag, input logic [7:0] cmd, input logic [23:0] a, input int n);
        logic [7:0] rx;
        logic       oa, oo;
        cs_lo();
        send_hdr(cmd, a);
        if (cmd == 8'h0B) begin
            xfer_byte(8'h00, rx, oa, oo);
            chk({tag, "_dummy_oe"}, oo, 1'b0);
        end
        for (int i = 0; i < n; i++) begin
            xfer_byte(8'h00, rx, oa, oo);
            chk(tag, rx, mem_model[(int'(a) + i) % MEM]);
            chk({tag, "_oe"}, oa, 1'b1);
        end
        cs_hi();
        chk({tag, "_lastcmd"}, last_cmd, cmd);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0]  rx;
        logic        oa, oo;
        logic [23:0] ra;
        logic [7:0]  jedec [4];

        resetn    = 1'b0;
        spi_csb   = 1'b1;
        spi_clk   = 1'b0;
        spi_mosi  = 1'b0;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < MEM; i++) mem_model[i] = 8'h00;
        jedec[0] = 8'hEF; jedec[1] = 8'h40; jedec[2] = 8'h18; jedec[3] = 8'h00;

        clks(3);
        chk("rst_miso", spi_miso, 1'b0);
        chk("rst_oe", spi_miso_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lastcmd", last_cmd, 8'h00);
        resetn = 1'b1;
        clks(4);

        // Host preload before touching memory from SPI; RAM contents start unknown.
        for (int i = 0; i < MEM; i++) load(i, 8'h00);
        load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);

        do_read("read0", 8'h03, 24'h000000, 4);
        do_read("fast2", 8'h0B, 24'h000002, 2);

        load(16'h3FFF, 8'hA5);
        do_read("wrap", 8'h03, 24'h003FFF, 2);
        do_read("wrap_hi", 8'h03, 24'h0C3FFF, 2);

        cs_lo();
        xfer_byte(8'h9F, rx, oa, oo);
        for (int i = 0; i < 4; i++) begin
            xfer_byte(8'h00, rx, oa, oo);
            chk("jedec", rx, jedec[i]);
            chk("jedec_oe", oa, 1'b1);
        end
        cs_hi();
        chk("jedec_lastcmd", last_cmd, 8'h9F);

        cs_lo();
        xfer_byte(8'hFF, rx, oa, oo);
        xfer_byte(8'h00, rx, oa, oo);
        chk("ff_oe", oo, 1'b0);
        cs_hi();
        cs_lo();
        xfer_byte(8'hAB, rx, oa, oo);
        xfer_byte(8'h00, rx, oa, oo);
        xfer_byte(8'h00, rx, oa, oo);
        chk("ab_oe", oo, 1'b0);
        cs_hi();
        chk("ab_lastcmd", last_cmd, 8'hAB);

        // Abort after 12 address bits, then a clean restart.
        cs_lo();
        xfer_byte(8'h03, rx, oa, oo);
        xfer_byte(8'h00, rx, oa, oo);
        for (int b = 0; b < 4; b++) begin
            spi_mosi = 1'b1;
            clks(HALF);
            spi_clk = 1'b1;
            clks(HALF);
            spi_clk = 1'b0;
        end
        chk("abort_busy_before", busy, 1'b1);
        spi_csb = 1'b1;
        clks(3);
        chk("abort_busy", busy, 1'b0);
        chk("abort_oe", spi_miso_oe, 1'b0);
        clks(2*HALF);
        do_read("restart", 8'h03, 24'h000001, 1);

        // Reset in the middle of a data byte.
        cs_lo();
        send_hdr(8'h03, 24'h000000);
        xfer_byte(8'h00, rx, oa, oo);
        for (int b = 0; b < 3; b++) begin
            clks(HALF);
            spi_clk = 1'b1;
            clks(HALF);
            spi_clk = 1'b0;
        end
        clks(HALF);
        chk("mid_oe_before", spi_miso_oe, 1'b1);
        resetn = 1'b0;
        clks(1);
        chk("mid_rst_oe", spi_miso_oe, 1'b0);
        chk("mid_rst_lastcmd", last_cmd, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        spi_csb = 1'b1;
        clks(3);
        resetn = 1'b1;
        clks(2*HALF);
        chk("post_rst_busy", busy, 1'b0);

        // Randomized loads and reads at arbitrary 24-bit addresses.
        for (int t = 0; t < 14; t++) begin
            for (int k = 0; k < 4; k++)
                load($urandom_range(MEM-1), 8'($urandom));
            ra = 24'($urandom);
            if ($urandom_range(3) == 0) ra[ADDR_W-1:0] = ADDR_W'(MEM - 1 - $urandom_range(2));
            for (int k = 0; k < 3; k++)
                load((int'(ra) + k) % MEM, 8'($urandom));
            do_read("rand", ($urandom_range(1) == 1) ? 8'h0B : 8'h03, ra, $urandom_range(4, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
